mem_copy_master: RTL and testbench

- Initiator side of the byte-wide data-memory interface: a block-copy engine that drives read/write strobes, address and write data, and captures read data.
- Copies len bytes from src to dst, one read cycle then one write cycle per byte.
- Sits beside the CPU datapath as a simple DMA/loader that fills or moves memory contents after reset.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_copy_ptr.sv | 29 ++
 rtl/mem_copy_master.sv | 122 ++++++++++++
 tb/tb_mem_copy_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, copy-engine state encoding and address type
//   DEF_ADDR_W / DEF_DATA_W / DEF_LEN_W : default address, data and length widths
//   copy_state_t                         : IDLE, READ, WRITE, DONE
//   addr_t                               : memory address of DEF_ADDR_W bits
package mem_pkg;

    localparam int DEF_ADDR_W = 13;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 14;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } copy_state_t;

    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/mem_copy_ptr.sv
// mem_copy_ptr: loadable address counter that wraps modulo 2^W
//   clock, reset_n : rising-edge clock, asynchronous active-low reset (clears value)
//   load           : take load_value at the next edge (wins over inc)
//   inc            : advance value by one at the next edge
//   load_value     : address to load
//   value          : current address
module mem_copy_ptr
    import mem_pkg::*;
#(
    parameter int W = DEF_ADDR_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_value,
    output logic [W-1:0] value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (inc)
            value <= value + 1'b1;
    end

endmodule

// File: rtl/mem_copy_master.sv
// mem_copy_master: byte-wide block-copy engine (one read then one write per byte)
//   clock, reset_n         : rising-edge clock, asynchronous active-low reset
//   start                  : copy request, only honoured in IDLE
//   src_addr, dst_addr,len : copy parameters, latched when start is accepted
//   busy                   : high in READ, WRITE and DONE
//   done                   : one-cycle completion pulse
//   mem_read, mem_write    : memory strobes, never high together
//   mem_address, mem_wdata : memory address and write data (0 when unused)
//   mem_rdata              : combinational read data for the current address
//   checksum               : only with MEM_COPY_CHECKSUM_EN defined; modulo-2^DATA_W
//                            sum of the bytes read in the current transfer
module mem_copy_master
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    copy_state_t       state, state_next;
    logic [ADDR_W-1:0] src_ptr, dst_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [DATA_W-1:0] hold;
    logic              accept;

    assign accept = (state == IDLE) && start;

    mem_copy_ptr #(.W(ADDR_W)) u_src_ptr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .inc        (state == READ),
        .load_value (src_addr),
        .value      (src_ptr)
    );

    mem_copy_ptr #(.W(ADDR_W)) u_dst_ptr (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (accept),
        .inc        (state == WRITE),
        .load_value (dst_addr),
        .value      (dst_ptr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Strobes, address and data are pure decodes of the state register and the
    // registered pointers, so they only change right after a clock edge.
    always_comb begin
        state_next  = state;
        busy        = state != IDLE;
        done        = state == DONE;
        mem_read    = state == READ;
        mem_write   = state == WRITE;
        mem_address = '0;
        mem_wdata   = '0;
        case (state)
            IDLE:    if (start) state_next = (len == '0) ? DONE : READ;
            READ: begin
                mem_address = src_ptr;
                state_next  = WRITE;
            end
            WRITE: begin
                mem_address = dst_ptr;
                mem_wdata   = hold;
                state_next  = (remaining == LEN_W'(1)) ? DONE : READ;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            hold      <= '0;
        end else begin
            if (accept)
                remaining <= len;
            else if (state == WRITE)
                remaining <= remaining - 1'b1;
            if (state == READ)
                hold <= mem_rdata;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            checksum <= '0;
        else if (accept)
            checksum <= '0;
        else if (state == READ)
            checksum <= checksum + mem_rdata;
    end
`endif

endmodule

// File: tb/tb_mem_copy_master.sv
// tb_mem_copy_master: randomized self-checking bench with a memory model and a byte-order copy reference
module tb_mem_copy_master;

    localparam int MSIZE = 8192;
    localparam int MAXC  = 80;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [12:0] src_addr = '0;
    logic [12:0] dst_addr = '0;
    logic [13:0] len = '0;
    logic        busy, done, mem_read, mem_write;
    logic [12:0] mem_address;
    logic [7:0]  mem_wdata, mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [7:0]  checksum;
    logic [7:0]  tr_sum [0:MAXC];
`endif

    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  mem [MSIZE];
    logic [7:0]  ref_mem [MSIZE];

    logic [3:0]  tr_ctl [0:MAXC];
    logic [12:0] tr_addr [0:MAXC];
    logic [7:0]  tr_wdata [0:MAXC];
    logic [3:0]  exp_ctl [0:MAXC];
    logic [12:0] exp_addr [0:MAXC];
    logic [7:0]  exp_wdata [0:MAXC];
    logic [7:0]  exp_sum;

    int checks = 0;
    int passes = 0;

    mem_copy_master dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .src_addr    (src_addr),
        .dst_addr    (dst_addr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_address];

    always @(posedge clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_write)
            mem[mem_address] <= mem_wdata;
    end

    task automatic poke(input int a, input int v);
        @(negedge clock);
        pre_we = 1'b1;
        pre_addr = 13'(a);
        pre_data = 8'(v);
        ref_mem[a] = 8'(v);
        @(posedge clock);
        #1 pre_we = 1'b0;
    endtask

    // Reference: bytes move strictly in order, each read seeing all earlier writes.
    // Expected per-cycle control word is {mem_read, mem_write, busy, done}.
    task automatic model_copy(input int s, input int d, input int n);
        logic [7:0] b;
        for (int c = 0; c <= MAXC; c++) begin
            exp_ctl[c] = 4'b0000;
            exp_addr[c] = '0;
            exp_wdata[c] = '0;
        end
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            b = ref_mem[(s + i) % MSIZE];
            exp_ctl[2*i+1] = 4'b1010;
            exp_addr[2*i+1] = 13'((s + i) % MSIZE);
            exp_ctl[2*i+2] = 4'b0110;
            exp_addr[2*i+2] = 13'((d + i) % MSIZE);
            exp_wdata[2*i+2] = b;
            ref_mem[(d + i) % MSIZE] = b;
            exp_sum = exp_sum + b;
        end
        exp_ctl[2*n+1] = 4'b0011;
    endtask

    task automatic drive_start(input int s, input int d, input int n);
        @(negedge clock);
        src_addr = 13'(s);
        dst_addr = 13'(d);
        len = 14'(n);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        src_addr = 13'($urandom);
        dst_addr = 13'($urandom);
        len = 14'($urandom);
    endtask

    task automatic capture(input int nc, input int restart_at);
        for (int c = 1; c <= nc; c++) begin
            @(negedge clock);
            tr_ctl[c] = {mem_read, mem_write, busy, done};
            tr_addr[c] = mem_address;
            tr_wdata[c] = mem_wdata;
`ifdef MEM_COPY_CHECKSUM_EN
            tr_sum[c] = checksum;
`endif
            if (c == restart_at) begin
                start = 1'b1;
                src_addr = 13'(1000);
                dst_addr = 13'(2000);
                len = 14'(2);
            end else
                start = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, mem_read, mem_write, mem_address, mem_wdata} !== 25'd0)
            $display("FAIL reset_outputs got %h want 0", {busy, done, mem_read, mem_write, mem_address, mem_wdata});
        else passes++;
`ifdef MEM_COPY_CHECKSUM_EN
        checks++;
        if (checksum !== 8'd0) $display("FAIL reset_checksum got %0d want 0", checksum);
        else passes++;
`endif
        for (int a = 0; a < MSIZE; a++) poke(a, $urandom_range(0, 255));
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({busy, done, mem_read, mem_write, mem_address, mem_wdata} !== 25'd0)
            $display("FAIL idle_outputs got %h want 0", {busy, done, mem_read, mem_write, mem_address, mem_wdata});
        else passes++;
    endtask

    task automatic test_transfers();
        int s, d, n, done_at, busy_n, done_n, bad;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                s = 0; d = 100; n = 4;
                for (int i = 0; i < 4; i++) poke(i, 11 * (i + 1));
            end else if (k == 1) begin
                s = 5; d = 6; n = 0;
            end else if (k == 2) begin
                s = 8190; d = 8191; n = 3;
                poke(8190, 1); poke(8191, 2); poke(0, 3);
            end else begin
                s = $urandom_range(0, MSIZE - 1);
                d = (k % 2 == 1) ? (s + $urandom_range(0, 4)) % MSIZE : $urandom_range(0, MSIZE - 1);
                n = $urandom_range(1, 30);
            end
            model_copy(s, d, n);
            drive_start(s, d, n);
            capture(2*n + 4, 0);
            done_at = 0; busy_n = 0; done_n = 0;
            for (int c = 1; c <= 2*n + 4; c++) begin
                checks++;
                if (tr_ctl[c] !== exp_ctl[c])
                    $display("FAIL ctl k=%0d cycle %0d got %b want %b", k, c, tr_ctl[c], exp_ctl[c]);
                else passes++;
                if (exp_ctl[c][3] || exp_ctl[c][2]) begin
                    checks++;
                    if (tr_addr[c] !== exp_addr[c])
                        $display("FAIL addr k=%0d cycle %0d got %0d want %0d", k, c, tr_addr[c], exp_addr[c]);
                    else passes++;
                end
                if (exp_ctl[c][2]) begin
                    checks++;
                    if (tr_wdata[c] !== exp_wdata[c])
                        $display("FAIL wdata k=%0d cycle %0d got %0d want %0d", k, c, tr_wdata[c], exp_wdata[c]);
                    else passes++;
                end
                if (tr_ctl[c][0] && done_at == 0) done_at = c;
                busy_n += int'(tr_ctl[c][1]);
                done_n += int'(tr_ctl[c][0]);
            end
            checks++;
            if (done_at !== 2*n + 1 || busy_n !== 2*n + 1 || done_n !== 1)
                $display("FAIL timing k=%0d got done@%0d busy=%0d pulses=%0d want %0d/%0d/1", k, done_at, busy_n, done_n, 2*n + 1, 2*n + 1);
            else passes++;
            bad = 0;
            for (int a = 0; a < MSIZE; a++) if (mem[a] !== ref_mem[a]) bad++;
            checks++;
            if (bad !== 0) $display("FAIL memory k=%0d got %0d wrong bytes want 0", k, bad);
            else passes++;
`ifdef MEM_COPY_CHECKSUM_EN
            checks++;
            if (tr_sum[2*n+1] !== exp_sum || tr_sum[2*n+4] !== exp_sum)
                $display("FAIL checksum k=%0d got %0d/%0d want %0d", k, tr_sum[2*n+1], tr_sum[2*n+4], exp_sum);
            else passes++;
`endif
            if (k == 0) begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (mem[100 + i] !== 8'(11 * (i + 1)))
                        $display("FAIL basic_dst[%0d] got %0d want %0d", i, mem[100 + i], 11 * (i + 1));
                    else passes++;
                end
            end
            if (k == 2) begin
                checks++;
                if ({mem[8191], mem[0], mem[1]} !== {8'd1, 8'd1, 8'd1})
                    $display("FAIL wrap got %0d,%0d,%0d want 1,1,1", mem[8191], mem[0], mem[1]);
                else passes++;
            end
        end
    endtask

    task automatic test_start_ignored();
        int bad, done_n;
        model_copy(40, 300, 4);
        drive_start(40, 300, 4);
        capture(14, 3);
        bad = 0; done_n = 0;
        for (int c = 1; c <= 14; c++) begin
            if (tr_ctl[c] !== exp_ctl[c]) bad++;
            if ((exp_ctl[c][3] || exp_ctl[c][2]) && tr_addr[c] !== exp_addr[c]) bad++;
            done_n += int'(tr_ctl[c][0]);
        end
        checks++;
        if (bad !== 0) $display("FAIL ignored_trace got %0d bad cycles want 0", bad);
        else passes++;
        checks++;
        if (done_n !== 1) $display("FAIL ignored_done_pulses got %0d want 1", done_n);
        else passes++;
        bad = 0;
        for (int a = 0; a < MSIZE; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL ignored_memory got %0d wrong bytes want 0", bad);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int done_n, bad, done_at;
        done_n = 0;
        drive_start(20, 200, 4);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            done_n += int'(done);
        end
        @(negedge clock);
        checks++;
        if (mem_write !== 1'b1 || mem_address !== 13'd201)
            $display("FAIL mid_cycle4 got wr=%b addr=%0d want wr=1 addr=201", mem_write, mem_address);
        else passes++;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, mem_read, mem_write, mem_address, mem_wdata} !== 25'd0)
            $display("FAIL mid_async_outputs got %h want 0", {busy, done, mem_read, mem_write, mem_address, mem_wdata});
        else passes++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            done_n += int'(done | busy | mem_read | mem_write);
        end
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            done_n += int'(done | busy | mem_read | mem_write);
        end
        checks++;
        if (done_n !== 0) $display("FAIL mid_activity got %0d active cycles want 0", done_n);
        else passes++;
        model_copy(20, 200, 1);
        bad = 0;
        for (int a = 0; a < MSIZE; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL mid_memory got %0d wrong bytes want 0", bad);
        else passes++;
        model_copy(60, 400, 2);
        drive_start(60, 400, 2);
        capture(8, 0);
        done_at = 0;
        for (int c = 8; c >= 1; c--) if (tr_ctl[c][0]) done_at = c;
        checks++;
        if (done_at !== 5) $display("FAIL mid_restart_done got cycle %0d want 5", done_at);
        else passes++;
        bad = 0;
        for (int a = 0; a < MSIZE; a++) if (mem[a] !== ref_mem[a]) bad++;
        checks++;
        if (bad !== 0) $display("FAIL mid_restart_memory got %0d wrong bytes want 0", bad);
        else passes++;
    endtask

`ifdef MEM_COPY_CHECKSUM_EN
    task automatic test_checksum();
        poke(500, 200); poke(501, 100); poke(502, 7);
        model_copy(500, 600, 3);
        drive_start(500, 600, 3);
        capture(10, 0);
        checks++;
        if (tr_sum[7] !== 8'd51 || tr_sum[10] !== 8'd51)
            $display("FAIL checksum_held got %0d/%0d want 51", tr_sum[7], tr_sum[10]);
        else passes++;
        model_copy(500, 700, 3);
        drive_start(500, 700, 3);
        capture(2, 0);
        checks++;
        if (tr_sum[1] !== 8'd0 || tr_sum[2] !== 8'd200)
            $display("FAIL checksum_clear got %0d/%0d want 0/200", tr_sum[1], tr_sum[2]);
        else passes++;
        capture(8, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_transfers();
        test_start_ignored();
        test_reset_mid();
`ifdef MEM_COPY_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
